// File: rtl/microc_pkg.sv
// microc_pkg: opcode map, ALU codes, control word and sequencer state encoding for microc.
package microc_pkg;
  localparam logic [5:0] OP_HALT = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000100;
  localparam logic [5:0] OP_JZ   = 6'b001000;
  localparam logic [5:0] OP_JNZ  = 6'b001010;
  localparam logic       PFX_ALU = 1'b1;
  localparam logic [1:0] PFX_LI  = 2'b01;
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_NOT  = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_NEGA = 3'b110;
  localparam logic [2:0] ALU_NEGB = 3'b111;
  typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} state_t;
  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] op;
  } ctrl_t;
  localparam ctrl_t CTRL_IDLE = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, wez: 1'b0, op: ALU_PASS};
endpackage

// File: rtl/uc_seq_if.sv
// uc_seq_if: datapath-facing status inputs and control outputs of the sequencer.
interface uc_seq_if #(parameter int CNT_W = 16);
  logic [5:0]       opcode;
  logic             z;
  logic             start;
  logic             dbg;
  logic             step;
  logic             s_inc;
  logic             s_inm;
  logic             we3;
  logic             wez;
  logic [2:0]       op;
  logic             pc_we;
  logic             halted;
  logic [CNT_W-1:0] retired;
  modport master (output opcode, z, start, dbg, step,
                  input  s_inc, s_inm, we3, wez, op, pc_we, halted, retired);
  modport slave  (input  opcode, z, start, dbg, step,
                  output s_inc, s_inm, we3, wez, op, pc_we, halted, retired);
endinterface

// File: rtl/uc_decode.sv
// uc_decode: combinational opcode/z decode into the raw, ungated control word.
module uc_decode
  import microc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       z,
  output ctrl_t      cw,
  output logic       is_halt
);
  assign is_halt  = opcode == OP_HALT;
  assign cw.s_inc = opcode == OP_J ? 1'b0 : opcode == OP_JZ ? ~z : opcode == OP_JNZ ? z : 1'b1;
  assign cw.s_inm = opcode[5:4] == PFX_LI;
  assign cw.we3   = opcode[5] == PFX_ALU || opcode[5:4] == PFX_LI;
  assign cw.wez   = opcode[5] == PFX_ALU;
  assign cw.op    = opcode[5] == PFX_ALU ? opcode[4:2] : ALU_PASS;
endmodule

// File: rtl/uc_seq.sv
// uc_seq: run/step/halt sequencer gating the decoded control word, plus retired counter.
module uc_seq
  import microc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic   clk,
  input logic   reset,
  uc_seq_if.slave bus
);
  ctrl_t            raw, gated;
  logic             is_halt, exec;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  uc_decode u_dec (.opcode(bus.opcode), .z(bus.z), .cw(raw), .is_halt(is_halt));

  // dbg outranks HALT in RUN; mode switches always spend one non-executing cycle
  always_comb begin
    state_d = state_q;
    exec    = 1'b0;
    case (state_q)
      IDLE: state_d = bus.start ? (bus.dbg ? STEP : RUN) : IDLE;
      RUN: begin
        state_d = bus.dbg ? STEP : is_halt ? HALT : RUN;
        exec    = ~bus.dbg & ~is_halt;
      end
      STEP: begin
        state_d = ~bus.dbg ? RUN : (bus.step & is_halt) ? HALT : STEP;
        exec    = bus.dbg & bus.step & ~is_halt;
      end
      default: state_d = HALT;
    endcase
    retired_d = retired_q + CNT_W'(exec);
    gated     = exec ? raw : CTRL_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign bus.s_inc   = gated.s_inc;
  assign bus.s_inm   = gated.s_inm;
  assign bus.we3     = gated.we3;
  assign bus.wez     = gated.wez;
  assign bus.op      = gated.op;
  assign bus.pc_we   = exec;
  assign bus.halted  = state_q == HALT;
  assign bus.retired = retired_q;
endmodule

// File: tb/tb_uc_seq.sv
// tb_uc_seq: directed checks of uc_seq decode, run/step/halt sequencing and counter wrap.
module tb_uc_seq;
  localparam logic [5:0] LI  = 6'b010000;
  localparam logic [5:0] ADD = 6'b101000;
  localparam logic [5:0] SUB = 6'b101100;
  localparam logic [5:0] J   = 6'b000100;
  localparam logic [5:0] JZ  = 6'b001000;
  localparam logic [5:0] JNZ = 6'b001010;
  localparam logic [5:0] NOP = 6'b000001;
  localparam logic [5:0] HLT = 6'b000000;
  // {pc_we, s_inc, s_inm, we3, wez, op}
  localparam logic [7:0] C_IDLE = 8'b0100_0000;
  localparam logic [7:0] C_LI   = 8'b1111_0000;
  localparam logic [7:0] C_ADD  = 8'b1101_1010;
  localparam logic [7:0] C_SUB  = 8'b1101_1011;
  localparam logic [7:0] C_JMP  = 8'b1000_0000;
  localparam logic [7:0] C_NXT  = 8'b1100_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [6:0] step_pat = 7'b0101010;

  always #5 clk = ~clk;

  uc_seq_if #(.CNT_W(16)) b ();
  uc_seq_if #(.CNT_W(4))  w ();
  uc_seq #(.CNT_W(16)) dut   (.clk(clk), .reset(reset), .bus(b));
  uc_seq #(.CNT_W(4))  dut_w (.clk(clk), .reset(reset), .bus(w));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic [7:0] exp);
    chk(tag, 32'({b.pc_we, b.s_inc, b.s_inm, b.we3, b.wez, b.op}), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [5:0] opc, input logic zz, input logic [7:0] exp);
    b.opcode = opc;
    b.z      = zz;
    #1;
    ctl(tag, exp);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    b.opcode = HLT; b.z = 1'b0; b.start = 1'b0; b.dbg = 1'b0; b.step = 1'b0;
    w.opcode = NOP; w.z = 1'b0; w.start = 1'b0; w.dbg = 1'b0; w.step = 1'b0;
    #2;
    ctl("rst_ctl", C_IDLE);
    chk("rst_halted", 32'(b.halted), 0);
    chk("rst_retired", 32'(b.retired), 0);
    b.start = 1'b1;
    b.opcode = ADD;
    tick();
    ctl("rst_hold", C_IDLE);
    reset = 1'b0;
    b.opcode = LI;
    #1;
    ctl("idle_noexec", C_IDLE);
    tick();
    b.start = 1'b0;
    cyc("li1", LI, 1'b0, C_LI);
    cyc("li2", LI, 1'b0, C_LI);
    cyc("add", ADD, 1'b0, C_ADD);
    cyc("sub", SUB, 1'b0, C_SUB);
    chk("retired4", 32'(b.retired), 4);
    cyc("jnz_z0", JNZ, 1'b0, C_JMP);
    chk("retired5", 32'(b.retired), 5);
    cyc("jnz_z1", JNZ, 1'b1, C_NXT);
    chk("retired6", 32'(b.retired), 6);
    cyc("jz_z1", JZ, 1'b1, C_JMP);
    chk("retired7", 32'(b.retired), 7);
    cyc("jz_z0", JZ, 1'b0, C_NXT);
    cyc("j", J, 1'b1, C_JMP);
    cyc("nop", NOP, 1'b0, C_NXT);
    chk("retired10", 32'(b.retired), 10);
    b.opcode = HLT;
    #1;
    ctl("halt_cyc", C_IDLE);
    chk("halt_not_yet", 32'(b.halted), 0);
    tick();
    chk("halted", 32'(b.halted), 1);
    b.start = 1'b1;
    cyc("halt_start", LI, 1'b0, C_IDLE);
    b.start = 1'b0;
    cyc("halt_stay", ADD, 1'b0, C_IDLE);
    chk("halt_sticky", 32'(b.halted), 1);
    chk("halt_frozen", 32'(b.retired), 10);

    do_reset();
    chk("rst2_halted", 32'(b.halted), 0);
    chk("rst2_retired", 32'(b.retired), 0);
    b.dbg = 1'b1;
    b.start = 1'b1;
    cyc("dbg_idle", LI, 1'b0, C_IDLE);
    b.start = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      b.step = step_pat[i];
      cyc(step_pat[i] ? "step_exec" : "step_wait", step_pat[i] ? LI : ADD, 1'b0, step_pat[i] ? C_LI : C_IDLE);
    end
    chk("step_retired", 32'(b.retired), 3);
    b.dbg = 1'b0;
    b.step = 1'b1;
    cyc("step_exit", LI, 1'b0, C_IDLE);
    chk("step_exit_cnt", 32'(b.retired), 3);
    cyc("run_again", LI, 1'b0, C_LI);
    chk("run_again_cnt", 32'(b.retired), 4);
    b.dbg = 1'b1;
    cyc("dbg_over_halt", HLT, 1'b0, C_IDLE);
    chk("dbg_not_halted", 32'(b.halted), 0);
    cyc("step_halt", HLT, 1'b0, C_IDLE);
    chk("step_halted", 32'(b.halted), 1);
    chk("step_halt_cnt", 32'(b.retired), 4);

    do_reset();
    b.dbg = 1'b0;
    b.step = 1'b0;
    b.start = 1'b1;
    cyc("ar_idle", ADD, 1'b0, C_IDLE);
    b.start = 1'b0;
    cyc("ar_add1", ADD, 1'b0, C_ADD);
    chk("ar_cnt1", 32'(b.retired), 1);
    #1;
    ctl("ar_add2", C_ADD);
    reset = 1'b1;
    #1;
    ctl("ar_async", C_IDLE);
    chk("ar_retired", 32'(b.retired), 0);
    #1;
    reset = 1'b0;
    tick();
    ctl("ar_state_idle", C_IDLE);

    w.start = 1'b1;
    tick();
    w.start = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk("wrap", 32'(w.retired), 32'(i % 16));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
